// File: rtl/n_bit_pg_restoring_divider_pkg.sv
// n_bit_pg_restoring_divider_pkg: shared FSM state type and default operand width for the restoring divider
package n_bit_pg_restoring_divider_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int DEF_N = 32;
endpackage

// File: rtl/n_bit_pg_ripple_subtractor.sv
// n_bit_pg_ripple_subtractor: W-bit PG ripple subtractor D=X-Y (ports: X, Y in [W:1]; D out [W:1]; borrow out, high when X<Y)
module n_bit_pg_ripple_subtractor #(
  parameter int W = 33
) (
  input  logic [W:1] X,
  input  logic [W:1] Y,
  output logic [W:1] D,
  output logic       borrow
);
  logic [W:1] g, p;
  logic [W:0] c;
  assign g = X & ~Y;
  assign p = X ^ ~Y;
  assign c[0] = 1'b1;
  for (genvar i = 1; i <= W; i++) begin : g_rip
    assign c[i] = g[i] | (p[i] & c[i-1]);
  end
  assign D = p ^ c[W-1:0];
  assign borrow = ~c[W];
endmodule

// File: rtl/n_bit_pg_restoring_divider.sv
// n_bit_pg_restoring_divider: sequential N-bit unsigned restoring divider, one quotient bit per clock
// Ports: clk, reset (sync, active-high), start, A/B [N:1] dividend/divisor, busy, done (1-cycle pulse),
//        Q/R [N:1] quotient/remainder (held until next result), div_by_zero.
// Macro DIVIDER_ZERO_DETECT_EN: when defined, B==0 skips the iterations and finishes in one cycle with div_by_zero=1.
module n_bit_pg_restoring_divider
  import n_bit_pg_restoring_divider_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [N:1] A,
  input  logic [N:1] B,
  output logic       busy,
  output logic       done,
  output logic [N:1] Q,
  output logic [N:1] R,
  output logic       div_by_zero
);
  localparam int CW = $clog2(N + 1);
  state_t state, next;
  logic [N+1:1] pr, t, d, pr_n;
  logic [N:1] qr, br, qr_n;
  logic [CW-1:0] cnt;
  logic bw, accept, last, zero;
`ifdef DIVIDER_ZERO_DETECT_EN
  assign zero = ~|B;
`else
  assign zero = 1'b0;
`endif
  // trial value: partial remainder shifted left with the next dividend bit entering
  assign t = {pr[N:1], qr[N]};
  n_bit_pg_ripple_subtractor #(.W(N + 1)) u_sub (
    .X(t),
    .Y({1'b0, br}),
    .D(d),
    .borrow(bw)
  );
  assign pr_n = bw ? t : d;
  assign qr_n = {qr[N-1:1], ~bw};
  assign busy = state == CALC;
  assign done = state == DONE;
  always_comb begin
    accept = start && state != CALC;
    last = cnt == CW'(1);
    next = accept ? (zero ? DONE : CALC) :
           state == CALC ? (last ? DONE : CALC) :
           IDLE;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk)
    if (reset) begin
      pr <= '0;
      qr <= '0;
      br <= '0;
      cnt <= '0;
      Q <= '0;
      R <= '0;
    end else if (accept) begin
      pr <= '0;
      qr <= A;
      br <= B;
      cnt <= CW'(N);
      if (zero) begin
        Q <= '1;
        R <= A;
      end
    end else if (state == CALC) begin
      pr <= pr_n;
      qr <= qr_n;
      cnt <= cnt - CW'(1);
      if (last) begin
        Q <= qr_n;
        R <= pr_n[N:1];
      end
    end
`ifdef DIVIDER_ZERO_DETECT_EN
  always_ff @(posedge clk)
    if (reset) div_by_zero <= 1'b0;
    else if (accept && zero) div_by_zero <= 1'b1;
    else if (state == CALC && last) div_by_zero <= 1'b0;
`else
  assign div_by_zero = 1'b0;
`endif
endmodule

// File: tb/tb_n_bit_pg_restoring_divider.sv
// tb_n_bit_pg_restoring_divider: scoreboard bench for the restoring divider against a plain-arithmetic model
module tb_n_bit_pg_restoring_divider;
  import n_bit_pg_restoring_divider_pkg::*;
  localparam int N = 32;
  typedef struct {
    logic [N:1] q;
    logic [N:1] r;
    logic       dz;
    int         lat;
    int         c0;
  } exp_t;
  logic clk = 0, reset = 1, start = 0;
  logic [N:1] a = '0, b = '0;
  logic busy, done, dz;
  logic [N:1] q, r, pq, pr;
  logic rst_d;
  int total = 0, bad = 0, cyc = 0;
  exp_t sb[$];
  exp_t e;
  n_bit_pg_restoring_divider #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .A(a), .B(b),
    .busy(busy), .done(done), .Q(q), .R(r), .div_by_zero(dz)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_d <= reset;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_d) begin
      chk("rst_q", q, 0);
      chk("rst_r", r, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dz", dz, 0);
      chk("rst_state_idle", dut.state == IDLE, 1);
    end else if (done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        e = sb.pop_front();
        chk("q", q, e.q);
        chk("r", r, e.r);
        chk("div_by_zero", dz, e.dz);
        chk("latency", cyc - e.c0, e.lat);
        chk("busy_at_done", busy, 0);
      end
    end else begin
      chk("q_hold", q, pq);
      chk("r_hold", r, pr);
    end
    pq = q;
    pr = r;
  end
  task automatic issue(input logic [N:1] x, input logic [N:1] y);
    exp_t n;
    n.q = (y == 0) ? '1 : x / y;
    n.r = (y == 0) ? x : x % y;
    n.dz = 1'b0;
    n.lat = N + 1;
`ifdef DIVIDER_ZERO_DETECT_EN
    if (y == 0) begin
      n.dz = 1'b1;
      n.lat = 1;
    end
`endif
    n.c0 = cyc;
    sb.push_back(n);
    a = x;
    b = y;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout actual=0 expected=1");
    end
  endtask
  initial begin
    logic [N:1] x, y;
    repeat (3) @(negedge clk);
    reset = 0;
    issue(100, 7); wait_done(); @(negedge clk);
    issue('1, 1); wait_done();
    issue(0, 5); wait_done(); @(negedge clk);
    issue(5, 0); wait_done(); @(negedge clk);
    issue(50, 3);
    repeat (5) @(negedge clk);
    a = 9; b = 9; start = 1;
    @(negedge clk);
    start = 0; a = 0; b = 0;
    wait_done();
    issue(9, 9); wait_done(); @(negedge clk);
    issue(100, 7);
    repeat (9) @(negedge clk);
    reset = 1;
    sb.delete();
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    issue(100, 7); wait_done();
    for (int k = 0; k < 40; k++) begin
      x = $urandom;
      case ($urandom_range(0, 4))
        0: y = $urandom_range(1, 15);
        1: y = 0;
        2: y = $urandom;
        3: begin x = $urandom_range(0, 1000); y = x + $urandom_range(1, 50); end
        default: y = x;
      endcase
      issue(x, y);
      wait_done();
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL pending_results actual=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/n_bit_pg_restoring_divider.md
# n_bit_pg_restoring_divider

Sequential N-bit unsigned restoring divider, the inverse operation to the team's PG carry-ripple adder. It computes quotient and remainder one bit per clock. Each iteration runs a trial subtraction through an (N+1)-bit PG ripple subtractor built from the same bitwise-PG, group-PG and sum equations. It sits beside the adder in the datapath as a multi-cycle arithmetic unit with a start/busy/done handshake.

## Interface
- N, 32, operand, quotient and remainder width; bits indexed [N:1]; N ≥ 2

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only in IDLE or DONE
- A  in  [N:1]  dividend; sampled on the accepting edge
- B  in  [N:1]  divisor; sampled on the accepting edge
- busy  out  1  high while in CALC
- done  out  1  one-cycle pulse; Q and R are valid from this cycle
- Q  out  [N:1]  quotient; registered and held until the next accepted start completes
- R  out  [N:1]  remainder; registered and held the same way
- div_by_zero  out  1  registered; valid with done

## Operation
- Internal state:
  - PR, the (N+1)-bit partial remainder
  - QR, the N-bit dividend/quotient shift register
  - BR, the latched divisor
  - CNT, an iteration counter of clog2(N+1) bits
- FSM states are IDLE, CALC and DONE.
- IDLE or DONE with start=1:
  - load PR=0, QR=A, BR=B, CNT=N
  - go to CALC
  - start=0 in DONE goes to IDLE.
- CALC iteration:
  - T = {PR[N:1], QR[N]}, i.e. a shift left by one with the QR MSB entering.
  - D = T − {0,BR} via the PG subtractor: G=T&~B', P=T^~B', carry-in 1; borrow = NOT carry-out.
  - If there is no borrow: PR=D and QR={QR[N-1:1],1}. Otherwise PR=T and QR={QR[N-1:1],0}.
  - CNT decrements by 1. When CNT reaches 1 the state goes to DONE and Q←QR', R←PR'[N:1] (the updated values).
- DONE: done=1 for exactly one cycle. A start in this cycle is accepted (back-to-back operation).
- start while in CALC is ignored, with no effect on the operation in flight.
- Divide by zero: the restoring algorithm naturally yields Q = all ones and R = A.
- Reset, including mid-operation:
  - state goes to IDLE; PR, QR, BR and CNT clear
  - Q, R, busy, done and div_by_zero all become 0.

## Timing
- Start accepted at edge k → busy=1 from k+1 through the edge k+N.
- Iterations occur on edges k+1 … k+N. done=1 and busy=0 in the cycle after edge k+N.
- Latency from the start edge to done is N+1 cycles; throughput is one operation per N+1 cycles.
- Q, R and div_by_zero change only on the edge entering DONE, or on reset.
- The combinational path per cycle is one (N+1)-bit ripple subtract plus a 2:1 mux.

## Configuration
- Macro `DIVIDER_ZERO_DETECT_EN`.
- Defined:
  - On the accepting edge, B==0 goes straight to DONE with Q = all ones, R=A and div_by_zero=1.
  - done arrives the cycle after start, a latency of 1.
- Undefined:
  - There is no detection; div_by_zero is tied to 0.
  - B==0 runs the full N iterations, giving the same Q and R at latency N+1.

## Structure
- A shared package holds the FSM state enum typedef (IDLE, CALC, DONE) and the default width constant.
- One sub-module, `n_bit_pg_ripple_subtractor`, parameterised on width:
  - inputs X, Y
  - outputs D and borrow
  - internally uses the bitwise-PG/group-PG/sum equations with Y inverted and carry-in 1.
- All sequencing is in the top module.

## Test plan
- A=100, B=7, N=32 → done 33 cycles after start; Q=14, R=2, div_by_zero=0.
- A=32'hFFFFFFFF, B=1 → Q=32'hFFFFFFFF, R=0. A=0, B=5 → Q=0, R=0.
- A=5, B=0:
  - with `DIVIDER_ZERO_DETECT_EN`: done 1 cycle after start, Q=32'hFFFFFFFF, R=5, div_by_zero=1
  - without it: the same Q/R at 33 cycles, with div_by_zero=0.
- Start 50/3, pulse start with 9/9 during CALC → that start is ignored; result Q=16, R=2. Then assert start in the DONE cycle with 9/9 → Q=1, R=0 after 33 more cycles.
- Reset asserted at iteration 10 of 100/7 → next cycle: busy, done, Q, R all 0 and state IDLE. A following start with 100/7 still gives 14/2.
- Random constrained regression against the reference model: Q=A/B and R=A%B for B≠0, checking Q and R stay stable between done pulses.
